// File: rtl/wb_cfg_arbiter.sv
// rtl/wb_cfg_arbiter.sv - two-requester round-robin arbiter onto a Wishbone register bus
module wb_cfg_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  rq_valid,
    input  logic [1:0]  rq_we,
    input  logic [15:0] rq_adr,
    input  logic [63:0] rq_wdata,
    output logic [1:0]  rq_ready,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  wb_adr,
    output logic [31:0] wb_dat_i,
    output logic        wb_we,
    output logic        wb_stb,
    output logic        wb_cyc,
    input  logic [31:0] wb_dat_o,
    input  logic        wb_ack,
    input  logic        wb_intr,
    output logic        intr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic [7:0]  adr_q, adr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        intr_q, intr_d;
    logic        gnt_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            adr_q   <= 8'd0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            intr_q  <= intr_d;
        end
    end

    // Both requesting: the one not served last wins; otherwise whichever is asking.
    always_comb begin
        if (rq_valid == 2'b11) begin
            gnt_idx = ~last_q;
        end else begin
            gnt_idx = rq_valid[1];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        owner_d   = owner_q;
        adr_d     = adr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        intr_d    = wb_intr;
        rq_ready  = 2'b00;
        rsp_valid = 2'b00;
        rsp_rdata = 32'd0;
        rsp_err   = 1'b0;
        wb_adr    = 8'd0;
        wb_dat_i  = 32'd0;
        wb_we     = 1'b0;
        wb_stb    = 1'b0;
        wb_cyc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rq_valid != 2'b00) begin
                    // Ready is masked during reset so a request is never seen as consumed.
                    if (!reset) begin
                        rq_ready = gnt_idx ? 2'b10 : 2'b01;
                    end
                    owner_d = gnt_idx;
                    last_d  = gnt_idx;
                    adr_d   = gnt_idx ? rq_adr[15:8] : rq_adr[7:0];
                    wdata_d = gnt_idx ? rq_wdata[63:32] : rq_wdata[31:0];
                    we_d    = rq_we[gnt_idx];
                    cnt_d   = 8'd0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                wb_cyc   = 1'b1;
                wb_stb   = 1'b1;
                wb_adr   = adr_q;
                wb_we    = we_q;
                wb_dat_i = wdata_q;
                if (wb_ack) begin
                    rdata_d = we_q ? 32'd0 : wb_dat_o;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (!reset) begin
                    rsp_valid = owner_q ? 2'b10 : 2'b01;
                    rsp_rdata = rdata_q;
                    rsp_err   = err_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign intr = intr_q;

endmodule
